usb_command_decoder: RTL and testbench
======================================

// Module: usb_command_decoder
// PURPOSE
// - Consumes the 16-bit host control words that the FX2 slave-FIFO interface writes out (write strobe + word, IFCLK domain).
// - Decodes them into a register bank, the acquisition start/stop level, one-cycle command pulses and a buffered burst-payload stream.
// - The payload stream carries Microroc slow-control words toward the chain loaders.
// - Sits between usb_synchronous_slavefifo and the MicrorocControl chains; command path only, no readback.
// PARAMETERS
// - PAYLOAD_DEPTH  4   payload FIFO depth in words, power of two, >=2
// - NUM_REGS       16  number of 8-bit configuration registers (max 16)
// PORTS
// - Clk           in   1             IFCLK-domain clock, rising edge; single clock domain
// - rst_n         in   1             reset, asynchronous, active-low
// - CmdWrEn       in   1             control word valid this cycle; no backpressure
// - CmdWord       in   16            [15:8] address/opcode, [7:0] data
// - RegFile       out  NUM_REGS*8    register bank, reg i at [8i+7:8i]
// - RegWrStrobe   out  1             1-cycle pulse on any register write
// - RegWrAddr     out  4             index written; valid with RegWrStrobe
// - AcqStartStop  out  1             acquisition run level
// - CmdPulse      out  8             1-cycle command pulses (SC load, counter reset, ...)
// - ParamData     out  16            payload word at FIFO head
// - ParamValid    out  1             payload FIFO not empty
// - ParamReady    in   1             consumer pops the head when ParamValid&&ParamReady
// - BurstActive   out  1             high while in BURST state
// - BurstDone     out  1             1-cycle pulse when the last payload word is accepted
// - Status        out  3             sticky errors {ZeroLen, Overflow, Illegal}
// BEHAVIOUR
// - Reset: RegFile=0, AcqStartStop=0, all strobes/pulses=0, FIFO empty, Status=0, state IDLE.
// - Reset asserted mid-burst: remaining count and FIFO contents are discarded.
// - Opcodes are decoded in IDLE only; every output updates on the edge after CmdWrEn (latency 1).
// - 0xA0-0xAF: reg[addr[3:0]]<=data; RegWrStrobe=1, RegWrAddr=addr[3:0]. Index >=NUM_REGS -> Illegal, no write.
// - 0xF0: data 0x01 -> AcqStartStop=1; 0x00 -> AcqStartStop=0; any other data -> Illegal, level unchanged.
// - 0xF1: CmdPulse<=data for exactly one cycle, then 0.
// - 0xF2: clears Status; data ignored.
// - 0xC0: burst header, N=data.
//   - N=0: set ZeroLen, stay IDLE.
//   - Otherwise go to BURST with remaining=N.
// - Any other address in IDLE -> Illegal; no other effect.
// - BURST state:
//   - Every CmdWrEn word is payload, whole 16 bits, never decoded as an opcode.
//   - Payload is pushed to the FIFO; remaining decrements per word whether or not the word is stored.
//   - When remaining reaches 0 (last word): BurstDone pulses, state returns to IDLE.
//   - The next word after that is decoded as an opcode.
// - FIFO: ParamData/ParamValid come from registered head (first-word fall-through).
//   - Push when full with no pop: word dropped, Overflow set.
//   - Full with pop in the same cycle: push accepted, no overflow.
//   - Empty FIFO: push becomes visible on ParamValid the next cycle.
//   - Occupancy never exceeds PAYLOAD_DEPTH; pointers wrap modulo depth.
// - CmdWrEn low: no state change except FIFO pops. Status bits are sticky until 0xF2 or reset.
// STRUCTURE
// - Shared package/header usb_cmd_defs: opcode constants (OP_REG_BASE=8'hA0, OP_ACQ=8'hF0, OP_PULSE=8'hF1, OP_CLR=8'hF2, OP_BURST=8'hC0).
// - Same header holds CmdPulse bit assignments and Status bit positions.
// - One sub-module: cmd_payload_fifo (synchronous FIFO, WIDTH=16, DEPTH=PAYLOAD_DEPTH, full/empty, simultaneous push/pop).
// - Top: 2-state FSM (IDLE, BURST), 8-bit remaining counter, register bank, output regs.
// TESTING
// - Writes 0xA305, 0xAF7E (NUM_REGS=16) -> reg3=0x05, reg15=0x7E, RegWrStrobe 1 cycle each, RegWrAddr 3 then 15.
// - 0xF001, then 0xF000, then 0xF002 -> AcqStartStop 1, then 0, then stays 0 with Status=3'b001.
// - 0xC003 + payloads 0xF001,0x1234,0xABCD with ParamReady=1 -> ParamData 0xF001,0x1234,0xABCD in order.
//   - AcqStartStop unchanged; BurstDone pulses once; next word 0xF101 gives CmdPulse=0x01 for one cycle.
// - 0xC006, six back-to-back payloads, ParamReady=0 (DEPTH=4) -> four words held, Overflow set, BurstActive falls after 6th word.
//   - Then 0xF200 -> Status=0.
// - 0xC000 -> ZeroLen set, BurstActive stays 0; next 0xA101 still writes reg1=0x01.
// - rst_n low after 2 of 5 payloads -> FIFO empty, state IDLE, all outputs at reset values.
//   - After release, 0xA202 writes reg2=0x02 and is not taken as payload.

Source files
------------

// File: rtl/usb_cmd_defs.sv
// Shared definitions for the USB control-word decoder: opcodes, pulse bits,
// status bit positions and the decoder state type.
package usb_cmd_defs;

  localparam logic [7:0] OP_REG_BASE = 8'hA0;
  localparam logic [7:0] OP_ACQ      = 8'hF0;
  localparam logic [7:0] OP_PULSE    = 8'hF1;
  localparam logic [7:0] OP_CLR      = 8'hF2;
  localparam logic [7:0] OP_BURST    = 8'hC0;

  localparam int unsigned PULSE_SC_LOAD  = 0;
  localparam int unsigned PULSE_CNT_RST  = 1;
  localparam int unsigned PULSE_PROBE_LD = 2;
  localparam int unsigned PULSE_RO_RST   = 3;

  localparam int unsigned STAT_ILLEGAL  = 0;
  localparam int unsigned STAT_OVERFLOW = 1;
  localparam int unsigned STAT_ZEROLEN  = 2;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

endpackage

// File: rtl/cmd_payload_fifo.sv
// Synchronous FIFO with first-word fall-through head; pushes while full are
// accepted only when a pop frees a slot in the same cycle.
module cmd_payload_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/usb_command_decoder.sv
// Decodes FX2 slave-FIFO control words into registers, acquisition level,
// command pulses and a buffered burst-payload stream.
module usb_command_decoder
  import usb_cmd_defs::*;
#(
  parameter int unsigned PAYLOAD_DEPTH = 4,
  parameter int unsigned NUM_REGS      = 16
) (
  input  logic                  Clk,
  input  logic                  rst_n,
  input  logic                  CmdWrEn,
  input  logic [15:0]           CmdWord,
  output logic [NUM_REGS*8-1:0] RegFile,
  output logic                  RegWrStrobe,
  output logic [3:0]            RegWrAddr,
  output logic                  AcqStartStop,
  output logic [7:0]            CmdPulse,
  output logic [15:0]           ParamData,
  output logic                  ParamValid,
  input  logic                  ParamReady,
  output logic                  BurstActive,
  output logic                  BurstDone,
  output logic [2:0]            Status
);

  state_e                state_q, state_d;
  logic [7:0]            rem_q, rem_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  logic                  strobe_q, strobe_d;
  logic [3:0]            wr_addr_q, wr_addr_d;
  logic                  acq_q, acq_d;
  logic [7:0]            pulse_q, pulse_d;
  logic                  done_q, done_d;
  logic [2:0]            status_q, status_d;
  logic                  fifo_push, fifo_empty, fifo_full, fifo_ovf;
  logic                  reg_hit;
  logic [7:0]            op, data;

  assign op   = CmdWord[15:8];
  assign data = CmdWord[7:0];

  cmd_payload_fifo #(
    .WIDTH (16),
    .DEPTH (PAYLOAD_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (CmdWord),
    .pop   (ParamReady),
    .dout  (ParamData),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // A pop in the same cycle frees the slot, so only a stalled full FIFO drops.
  assign fifo_ovf = fifo_push && fifo_full && !ParamReady;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    regs_d    = regs_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    acq_d     = acq_q;
    pulse_d   = '0;
    done_d    = 1'b0;
    status_d  = status_q;
    fifo_push = 1'b0;
    reg_hit   = 1'b0;
    if (CmdWrEn) begin
      if (state_q == ST_BURST) begin
        fifo_push = 1'b1;
        rem_d     = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end else if (op[7:4] == OP_REG_BASE[7:4]) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (op[3:0] == 4'(i)) begin
            reg_hit          = 1'b1;
            regs_d[i*8 +: 8] = data;
          end
        end
        if (reg_hit) begin
          strobe_d  = 1'b1;
          wr_addr_d = op[3:0];
        end else begin
          status_d[STAT_ILLEGAL] = 1'b1;
        end
      end else begin
        case (op)
          OP_ACQ: begin
            if (data == 8'h01)      acq_d = 1'b1;
            else if (data == 8'h00) acq_d = 1'b0;
            else                    status_d[STAT_ILLEGAL] = 1'b1;
          end
          OP_PULSE: pulse_d  = data;
          OP_CLR:   status_d = '0;
          OP_BURST: begin
            if (data == 8'h00) begin
              status_d[STAT_ZEROLEN] = 1'b1;
            end else begin
              rem_d   = data;
              state_d = ST_BURST;
            end
          end
          default: status_d[STAT_ILLEGAL] = 1'b1;
        endcase
      end
    end
    if (fifo_ovf) status_d[STAT_OVERFLOW] = 1'b1;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      regs_q    <= '0;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      acq_q     <= 1'b0;
      pulse_q   <= '0;
      done_q    <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      regs_q    <= regs_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      acq_q     <= acq_d;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      status_q  <= status_d;
    end
  end

  assign RegFile      = regs_q;
  assign RegWrStrobe  = strobe_q;
  assign RegWrAddr    = wr_addr_q;
  assign AcqStartStop = acq_q;
  assign CmdPulse     = pulse_q;
  assign ParamValid   = !fifo_empty;
  assign BurstActive  = (state_q == ST_BURST);
  assign BurstDone    = done_q;
  assign Status       = status_q;

endmodule

// File: tb/tb_usb_command_decoder.sv
// Randomized bench for usb_command_decoder against a queue-based reference model.
module tb_usb_command_decoder;
  import usb_cmd_defs::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREG  = 16;

  logic              Clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              CmdWrEn = 1'b0;
  logic [15:0]       CmdWord = '0;
  logic              ParamReady = 1'b0;
  logic [NREG*8-1:0] RegFile;
  logic              RegWrStrobe;
  logic [3:0]        RegWrAddr;
  logic              AcqStartStop;
  logic [7:0]        CmdPulse;
  logic [15:0]       ParamData;
  logic              ParamValid;
  logic              BurstActive;
  logic              BurstDone;
  logic [2:0]        Status;

  always #5 Clk = ~Clk;

  usb_command_decoder #(
    .PAYLOAD_DEPTH (DEPTH),
    .NUM_REGS      (NREG)
  ) dut (
    .Clk          (Clk),
    .rst_n        (rst_n),
    .CmdWrEn      (CmdWrEn),
    .CmdWord      (CmdWord),
    .RegFile      (RegFile),
    .RegWrStrobe  (RegWrStrobe),
    .RegWrAddr    (RegWrAddr),
    .AcqStartStop (AcqStartStop),
    .CmdPulse     (CmdPulse),
    .ParamData    (ParamData),
    .ParamValid   (ParamValid),
    .ParamReady   (ParamReady),
    .BurstActive  (BurstActive),
    .BurstDone    (BurstDone),
    .Status       (Status)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit [7:0]    m_reg [NREG];
  bit          m_acq;
  bit [7:0]    m_pulse;
  bit          m_strobe;
  bit [3:0]    m_addr;
  logic [15:0] m_q [$];
  int          m_rem;
  bit          m_burst;
  bit          m_done;
  bit [2:0]    m_stat;   // {ZeroLen, Overflow, Illegal}

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] m_regfile();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++) r[i*8 +: 8] = m_reg[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_acq = 0; m_pulse = '0; m_strobe = 0; m_addr = '0;
    m_q.delete(); m_rem = 0; m_burst = 0; m_done = 0; m_stat = '0;
  endtask

  task automatic model_step(input bit en, input logic [15:0] w, input bit rdy);
    bit       was_full;
    bit       pop;
    int       idx;
    bit [7:0] op;
    bit [7:0] d;
    was_full = (m_q.size() == DEPTH);
    pop      = rdy && (m_q.size() > 0);
    op       = w[15:8];
    d        = w[7:0];
    m_strobe = 0; m_pulse = '0; m_done = 0;
    if (pop) void'(m_q.pop_front());
    if (en) begin
      if (m_burst) begin
        if (!was_full || pop) m_q.push_back(w);
        else m_stat[1] = 1;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_burst = 0; m_done = 1; end
      end else if (op >= 8'hA0 && op <= 8'hAF) begin
        idx = int'(op) - 'hA0;
        if (idx < NREG) begin
          m_reg[idx] = d; m_strobe = 1; m_addr = idx[3:0];
        end else m_stat[0] = 1;
      end else if (op == 8'hF0) begin
        if (d == 8'h01) m_acq = 1;
        else if (d == 8'h00) m_acq = 0;
        else m_stat[0] = 1;
      end else if (op == 8'hF1) m_pulse = d;
      else if (op == 8'hF2) m_stat = '0;
      else if (op == 8'hC0) begin
        if (d == 0) m_stat[2] = 1;
        else begin m_burst = 1; m_rem = int'(d); end
      end else m_stat[0] = 1;
    end
  endtask

  task automatic check_all();
    chk("regfile", 128'(RegFile), m_regfile());
    chk("strobe", 128'(RegWrStrobe), 128'(m_strobe));
    if (m_strobe) chk("wr_addr", 128'(RegWrAddr), 128'(m_addr));
    chk("acq", 128'(AcqStartStop), 128'(m_acq));
    chk("pulse", 128'(CmdPulse), 128'(m_pulse));
    chk("valid", 128'(ParamValid), 128'(m_q.size() > 0));
    if (m_q.size() > 0) chk("data", 128'(ParamData), 128'(m_q[0]));
    chk("burst_active", 128'(BurstActive), 128'(m_burst));
    chk("burst_done", 128'(BurstDone), 128'(m_done));
    chk("status", 128'(Status), 128'(m_stat));
  endtask

  task automatic tick(input bit en, input logic [15:0] w, input bit rdy);
    @(negedge Clk);
    check_all();
    CmdWrEn = en; CmdWord = w; ParamReady = rdy;
    @(posedge Clk);
    model_step(en, w, rdy);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    check_all();
    CmdWrEn = 0; rst_n = 0;
    model_reset();
    #1;
    check_all();
    chk("rst_valid", 128'(ParamValid), 128'(1'b0));
    @(negedge Clk);
    rst_n = 1;
  endtask

  initial begin
    logic [15:0] w;
    int unsigned r;
    model_reset();
    #2;
    check_all();
    do_reset();

    tick(1, 16'hA305, 0); #1;
    chk("w3_strobe", 128'(RegWrStrobe), 128'(1'b1));
    chk("w3_addr", 128'(RegWrAddr), 128'(4'd3));
    chk("w3_reg", 128'(RegFile[31:24]), 128'(8'h05));
    tick(1, 16'hAF7E, 0); #1;
    chk("w15_addr", 128'(RegWrAddr), 128'(4'd15));
    chk("w15_reg", 128'(RegFile[127:120]), 128'(8'h7E));
    tick(0, 16'h0000, 0); #1;
    chk("strobe_1cyc", 128'(RegWrStrobe), 128'(1'b0));

    tick(1, 16'hF001, 0); #1; chk("acq_on", 128'(AcqStartStop), 128'(1'b1));
    tick(1, 16'hF000, 0); #1; chk("acq_off", 128'(AcqStartStop), 128'(1'b0));
    tick(1, 16'hF002, 0); #1;
    chk("acq_bad", 128'(AcqStartStop), 128'(1'b0));
    chk("illegal", 128'(Status), 128'(3'b001));
    tick(1, 16'hF200, 0);

    tick(1, 16'hC003, 1);
    tick(1, 16'hF001, 1); #1; chk("pay0", 128'(ParamData), 128'(16'hF001));
    tick(1, 16'h1234, 1); #1; chk("pay1", 128'(ParamData), 128'(16'h1234));
    tick(1, 16'hABCD, 1); #1;
    chk("pay2", 128'(ParamData), 128'(16'hABCD));
    chk("done", 128'(BurstDone), 128'(1'b1));
    chk("acq_kept", 128'(AcqStartStop), 128'(1'b0));
    tick(1, 16'hF101, 1); #1;
    chk("pulse_sc", 128'(CmdPulse[PULSE_SC_LOAD]), 128'(1'b1));
    chk("done_1cyc", 128'(BurstDone), 128'(1'b0));
    tick(0, 16'h0000, 1); #1; chk("pulse_clr", 128'(CmdPulse), 128'(8'h00));

    tick(1, 16'hC006, 0);
    for (int i = 0; i < 6; i++) tick(1, 16'h1000 + 16'(i), 0);
    #1;
    chk("ovf_burst_end", 128'(BurstActive), 128'(1'b0));
    chk("ovf_flag", 128'(Status[STAT_OVERFLOW]), 128'(1'b1));
    tick(1, 16'hF200, 0); #1; chk("clr", 128'(Status), 128'(3'b000));
    for (int i = 0; i < 5; i++) tick(0, 16'h0000, 1);

    tick(1, 16'hC000, 0); #1;
    chk("zerolen", 128'(Status[STAT_ZEROLEN]), 128'(1'b1));
    chk("zerolen_idle", 128'(BurstActive), 128'(1'b0));
    tick(1, 16'hA101, 0); #1; chk("reg1", 128'(RegFile[15:8]), 128'(8'h01));

    tick(1, 16'hC005, 0);
    tick(1, 16'h5555, 0);
    tick(1, 16'h6666, 0);
    do_reset();
    tick(1, 16'hA202, 0); #1;
    chk("reg2", 128'(RegFile[23:16]), 128'(8'h02));
    chk("reg2_nopay", 128'(ParamValid), 128'(1'b0));

    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: w = {4'hA, 4'($urandom_range(0, 15)), 8'($urandom)};
        3:       w = {8'hF0, 8'($urandom_range(0, 2))};
        4:       w = {8'hF1, 8'($urandom)};
        5:       w = {8'hF2, 8'($urandom)};
        6, 7:    w = {8'hC0, 8'($urandom_range(0, 7))};
        default: w = 16'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0);
    end

    @(negedge Clk);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
